fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ADDR_W, default 12, instruction-memory word-address width.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-004 stall  input  1  decode-side hold request; 1 = freeze fetch and the output latch.
REQ-005 redirect  input  1  taken branch or jump; has priority over stall.
REQ-006 redirect_target  input  32  new PC; bits above ADDR_W-1 ignored.
REQ-007 imem_addr  output  ADDR_W  word address to synchronous IMEM; IMEM returns data one cycle later.
REQ-008 imem_data  input  32  IMEM read data for the address presented on the previous cycle.
REQ-009 if_instr  output  32  registered instruction handed to the decoder.
REQ-010 if_pc_plus1  output  32  registered PC+1 of if_instr; used for branch and jal arithmetic.
REQ-011 if_valid  output  1  registered; 1 = if_instr is a real fetched instruction; 0 = bubble.

Function
REQ-012 Internal state: pc_r (next issue address), resp_pc_r (address whose data is on imem_data), resp_valid_r, plus the three output registers.
REQ-013 imem_addr SHALL be redirect ? redirect_target[ADDR_W-1:0] : stall ? resp_pc_r : pc_r; this is the only combinational input-to-output path.
REQ-014 FSM states: FILL (resp_valid_r=0), RUN (resp_valid_r=1, stall=0), HOLD (resp_valid_r=1, stall=1).
REQ-015 RUN edge: pc_r<=pc_r+1, resp_pc_r<=pc_r, resp_valid_r<=1, if_instr<=imem_data, if_pc_plus1<=resp_pc_r+1, if_valid<=1.
REQ-016 HOLD edge (stall=1, redirect=0): pc_r, resp_pc_r, resp_valid_r and all outputs hold; the re-issued resp_pc_r keeps imem_data stable for release.
REQ-017 Stall release: the first RUN edge loads the held response; no instruction is lost or duplicated.
REQ-018 FILL edge without stall: output loads bubble (if_instr=32'h0, if_valid=0, if_pc_plus1=0), resp_pc_r<=pc_r, resp_valid_r<=1, pc_r<=pc_r+1; next state RUN.
REQ-019 FILL edge with stall: all state holds; stays FILL.
REQ-020 Redirect edge, regardless of stall or state: pc_r<=target+1, resp_pc_r<=target, resp_valid_r<=1, output loads bubble; the target instruction appears on the following edge (exactly one bubble).
REQ-021 pc_r and resp_pc_r wrap modulo 2^ADDR_W; if_pc_plus1 SHALL be the 32-bit zero-extended resp_pc_r+1 without wrap (4095 -> 4096 for ADDR_W=12).
REQ-022 Bubble encoding is 32'h0, which the decoder treats as a harmless ALU no-op.

Reset
REQ-023 When reset_n=0 at an edge: pc_r=0, resp_pc_r=0, resp_valid_r=0, if_instr=0, if_pc_plus1=0, if_valid=0; state FILL.
REQ-024 Reset overrides redirect and stall, including mid-stall and mid-redirect.
REQ-025 The instruction at address 0 reaches the output on the 2nd edge after reset_n rises, absent stall.

Configuration
REQ-026 Macro FETCH_PERF_CNT_EN defined: adds outputs fetch_count[31:0], incremented on each edge that loads if_valid=1, and bubble_count[31:0], incremented on each edge that loads a bubble; both reset to 0 and wrap at 2^32.
REQ-027 Macro FETCH_PERF_CNT_EN undefined: ports and counters absent; all other behaviour is identical.

Structure
REQ-028 Shared header fetch_defs.vh SHALL hold NOP_INSTR (32'h0), RESET_PC (0) and the FSM state encodings FILL/RUN/HOLD.
REQ-029 One sub-module, pc_reg: an ADDR_W-wide register with load enable, load value and synchronous active-low reset; instantiated for pc_r and resp_pc_r.

Verification
REQ-030 Reset release with IMEM[0..3]=A,B,C,D and no stall -> edges 1..5 output bubble, A(pc+1=1), B(2), C(3), D(4).
REQ-031 Stall held 3 cycles while if_instr=B -> B held, imem_addr constant at 2; after release C then D follow with no gap or repeat.
REQ-032 Redirect to 0x40 while if_instr=B, stall=1 the same cycle -> imem_addr=0x40 combinationally; next edge bubble; following edge IMEM[0x40] with if_pc_plus1=0x41.
REQ-033 Redirect to 0xFFF -> IMEM[0xFFF] with if_pc_plus1=0x1000, then IMEM[0x000] with if_pc_plus1=1.
REQ-034 reset_n=0 asserted during a stall with a redirect pending -> all outputs 0 next edge, redirect ignored, address-0 instruction on the 2nd edge after release.
REQ-035 With FETCH_PERF_CNT_EN defined, run REQ-030 then REQ-032 -> counters match the number of valid and bubble loads exactly.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch constants: bubble encoding, reset PC, FSM states
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          RESET_PC  = 0;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// rtl/fetch_stage_pc_reg.sv - ADDR_W-wide address register with load enable and sync active-low reset
module pc_reg
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    output logic [ADDR_W-1:0] value
);

    logic [ADDR_W-1:0] value_q;
    logic [ADDR_W-1:0] value_d;

    always_comb begin
        value_d = load ? load_value : value_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            value_q <= ADDR_W'(RESET_PC);
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage for a synchronous IMEM with stall/redirect
// Optional FETCH_PERF_CNT_EN adds fetch_count/bubble_count outputs.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc_plus1,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       fetch_count,
    output logic [31:0]       bubble_count,
`endif
    output logic              if_valid
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d, target;
    logic              pc_ld, resp_ld, resp_valid;
    logic [31:0]       instr_q, instr_d, pc_plus1_q, pc_plus1_d;
    logic              valid_q, valid_d;
    logic              load_valid, load_bubble;

    pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (pc_ld),
        .load_value (pc_d),
        .value      (pc_q)
    );

    pc_reg #(.ADDR_W(ADDR_W)) u_resp_pc_reg (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (resp_ld),
        .load_value (resp_pc_d),
        .value      (resp_pc_q)
    );

    assign resp_valid = (state_q != FILL);
    assign target     = redirect_target[ADDR_W-1:0];

    always_comb begin
        state_d     = state_q;
        pc_ld       = 1'b0;
        resp_ld     = 1'b0;
        pc_d        = pc_q + ADDR_W'(1);
        resp_pc_d   = pc_q;
        load_valid  = 1'b0;
        load_bubble = 1'b0;
        instr_d     = instr_q;
        pc_plus1_d  = pc_plus1_q;
        valid_d     = valid_q;

        if (redirect) begin
            pc_ld       = 1'b1;
            pc_d        = target + ADDR_W'(1);
            resp_ld     = 1'b1;
            resp_pc_d   = target;
            state_d     = RUN;
            load_bubble = 1'b1;
        end else if (stall) begin
            state_d = resp_valid ? HOLD : FILL;
        end else begin
            pc_ld   = 1'b1;
            resp_ld = 1'b1;
            state_d = RUN;
            if (resp_valid) begin
                load_valid = 1'b1;
            end else begin
                load_bubble = 1'b1;
            end
        end

        if (load_bubble) begin
            instr_d    = NOP_INSTR;
            pc_plus1_d = 32'd0;
            valid_d    = 1'b0;
        end else if (load_valid) begin
            instr_d    = imem_data;
            pc_plus1_d = 32'(resp_pc_q) + 32'd1;  // zero-extended, no wrap at 2^ADDR_W
            valid_d    = 1'b1;
        end

        // Re-issuing resp_pc_q during a stall keeps imem_data stable for release.
        imem_addr = redirect ? target : (stall ? resp_pc_q : pc_q);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= FILL;
            instr_q    <= NOP_INSTR;
            pc_plus1_q <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            pc_plus1_q <= pc_plus1_d;
            valid_q    <= valid_d;
        end
    end

    assign if_instr    = instr_q;
    assign if_pc_plus1 = pc_plus1_q;
    assign if_valid    = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d, bubble_count_q, bubble_count_d;

    always_comb begin
        fetch_count_d  = fetch_count_q + (load_valid ? 32'd1 : 32'd0);
        bubble_count_d = bubble_count_q + (load_bubble ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_count_q  <= 32'd0;
            bubble_count_q <= 32'd0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage against an instruction-stream model
module tb_fetch_stage;

    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          reset_n, stall, redirect;
    logic [31:0]   redirect_target, imem_data;
    logic [AW-1:0] imem_addr;
    logic [31:0]   if_instr, if_pc_plus1;
    logic          if_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   fetch_count, bubble_count;
`endif

    always #5 clock = ~clock;

    fetch_stage #(.ADDR_W(AW)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .if_instr        (if_instr),
        .if_pc_plus1     (if_pc_plus1),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count     (fetch_count),
        .bubble_count    (bubble_count),
`endif
        .if_valid        (if_valid)
    );

    logic [31:0] mem [0:4095];

    always @(posedge clock) imem_data <= mem[imem_addr];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcp1;
        logic        valid;
        int          id;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;
    bit   running = 1'b1;

    // Model: the next address to deliver, and whether a response is already in flight.
    int   m_next = 0;
    bit   m_primed = 1'b0;
    bit   m_known = 1'b0;
    int   m_fetch = 0;
    int   m_bubble = 0;

    task automatic step(input bit rst_n, input bit stl, input bit rd, input logic [31:0] tgt);
        exp_t e;
        int   exp_addr;
        reset_n = rst_n;
        stall = stl;
        redirect = rd;
        redirect_target = tgt;
        #1;
        if (m_known) begin
            if (rd) exp_addr = int'(tgt % 32'd4096);
            else if (stl) exp_addr = m_next;
            else if (m_primed) exp_addr = (m_next + 1) % 4096;
            else exp_addr = m_next;
            checks++;
            if (imem_addr !== exp_addr[AW-1:0]) begin
                errors++;
                $display("FAIL imem_addr step %0d: got %0h want %0h", step_no, imem_addr, exp_addr[AW-1:0]);
            end
        end
        e.id = step_no;
        e.instr = 32'h0;
        e.pcp1 = 32'h0;
        e.valid = 1'b0;
        if (!rst_n) begin
            m_next = 0;
            m_primed = 1'b0;
            m_known = 1'b1;
            m_fetch = 0;
            m_bubble = 0;
        end else if (rd) begin
            m_next = int'(tgt % 32'd4096);
            m_primed = 1'b1;
            m_bubble++;
        end else if (stl) begin
            e = last_exp;
            e.id = step_no;
        end else if (!m_primed) begin
            m_primed = 1'b1;
            m_bubble++;
        end else begin
            e.instr = mem[m_next];
            e.pcp1 = 32'(m_next + 1);
            e.valid = 1'b1;
            m_next = (m_next + 1) % 4096;
            m_fetch++;
        end
        last_exp = e;
        q.push_back(e);
        step_no++;
        @(negedge clock);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() == 0) begin
                if (running) begin
                    errors++;
                    $display("FAIL scoreboard: output edge with no expectation queued");
                end
            end else begin
                e = q.pop_front();
                checks++;
                if (if_valid !== e.valid || if_instr !== e.instr || if_pc_plus1 !== e.pcp1) begin
                    errors++;
                    $display("FAIL output step %0d: got v=%0b i=%08h p=%08h want v=%0b i=%08h p=%08h",
                             e.id, if_valid, if_instr, if_pc_plus1, e.valid, e.instr, e.pcp1);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] tgt;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom | 32'h1;

        // Reset release, fill, then stall while B is on the output.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        repeat (2) step(1, 0, 0, 0);

        // Redirect to 0x40 coinciding with a stall.
        step(0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 1, 32'h40);
        repeat (2) step(1, 0, 0, 0);

        // Redirect to the last word: if_pc_plus1 must not wrap, the PC must.
        step(1, 0, 1, 32'hFFF);
        repeat (3) step(1, 0, 0, 0);

        // Reset during a stall with a redirect pending.
        step(1, 1, 0, 0);
        step(0, 1, 1, 32'h123);
        repeat (3) step(1, 0, 0, 0);

        // Stall during FILL, and redirect upper bits ignored.
        step(0, 0, 0, 0);
        repeat (2) step(1, 1, 0, 0);
        repeat (2) step(1, 0, 0, 0);
        step(1, 0, 1, 32'hABCD_E7FE);
        repeat (4) step(1, 0, 0, 0);

        for (int n = 0; n < 500; n++) begin
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFF - 32'($urandom_range(0, 2))) : $urandom;
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0), tgt);
        end

        running = 1'b0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (fetch_count !== 32'(m_fetch)) begin
            errors++;
            $display("FAIL fetch_count: got %0d want %0d", fetch_count, m_fetch);
        end
        checks++;
        if (bubble_count !== 32'(m_bubble)) begin
            errors++;
            $display("FAIL bubble_count: got %0d want %0d", bubble_count, m_bubble);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
